// File: rtl/reg_write_arb_pkg.sv
// Shared types for the two-requester register write arbiter: FSM state
// encoding, requester ids and the fixed address width.
package reg_write_arb_pkg;

  localparam int AW = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/reg_write_arb_rr_arb2.sv
// Two-way round-robin decision: a lone requester wins outright, a tie goes
// to whichever requester was not granted last. Purely combinational.
module rr_arb2
  import reg_write_arb_pkg::*;
(
  input  logic    req_a_in,
  input  logic    req_b_in,
  input  req_id_t last_grant_in,
  output logic    valid_out,
  output req_id_t winner_out
);

  always_comb begin
    valid_out  = req_a_in | req_b_in;
    winner_out = REQ_A;
    if (req_a_in && req_b_in) begin
      winner_out = other_req(last_grant_in);
    end else if (req_b_in) begin
      winner_out = REQ_B;
    end
  end

endmodule

// File: rtl/reg_write_arb.sv
// Arbitrates write requests from two requesters onto a bank of target
// registers: one-hot set strobe plus broadcast data, one write at a time.
module reg_write_arb
  import reg_write_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  req_a_in,
  input  logic                  req_b_in,
  input  logic [AW-1:0]         addr_a_in,
  input  logic [AW-1:0]         addr_b_in,
  input  logic [DATA_WIDTH-1:0] data_a_in,
  input  logic [DATA_WIDTH-1:0] data_b_in,
  output logic                  ack_a_out,
  output logic                  ack_b_out,
  output logic [NUM_REGS-1:0]   set_out,
  output logic [DATA_WIDTH-1:0] wr_data_out,
  output logic                  busy_out,
  output logic [7:0]            wr_count_out
);

  state_t                state_q, state_d;
  req_id_t               winner_q, winner_d;
  req_id_t               last_grant_q, last_grant_d;
  logic [NUM_REGS-1:0]   set_q, set_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [7:0]            wr_count_q, wr_count_d;

  logic                  arb_valid;
  req_id_t               arb_winner;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   sel_set;
  logic                  winner_req;

  rr_arb2 u_arb (
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .last_grant_in (last_grant_q),
    .valid_out     (arb_valid),
    .winner_out    (arb_winner)
  );

  // Addresses at or beyond NUM_REGS decode to an all-zero strobe.
  always_comb begin
    sel_addr = (arb_winner == REQ_A) ? addr_a_in : addr_b_in;
    sel_data = (arb_winner == REQ_A) ? data_a_in : data_b_in;
    sel_set  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_set[i] = (int'(sel_addr) == i);
    end
    winner_req = (winner_q == REQ_A) ? req_a_in : req_b_in;
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    set_d        = '0;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          winner_d     = arb_winner;
          last_grant_d = arb_winner;
          wr_data_d    = sel_data;
          set_d        = sel_set;
          ack_a_d      = (arb_winner == REQ_A);
          ack_b_d      = (arb_winner == REQ_B);
          state_d      = WRITE;
        end
      end
      WRITE: begin
        wr_count_d = wr_count_q + 8'd1;
        state_d    = RELEASE;
      end
      RELEASE: begin
        if (!winner_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe and ack are loaded on the capture edge so they are live
  // exactly for the WRITE cycle.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      winner_q     <= REQ_A;
      last_grant_q <= REQ_B;
      set_q        <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      set_q        <= set_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign ack_a_out    = ack_a_q;
  assign ack_b_out    = ack_b_q;
  assign set_out      = set_q;
  assign wr_data_out  = wr_data_q;
  assign wr_count_out = wr_count_q;
  assign busy_out     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_write_arb.sv
// Self-checking bench for reg_write_arb: directed scenarios plus random
// rounds against a transaction-level round-robin model.
module tb_reg_write_arb;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       req_a_in = 1'b0;
  logic       req_b_in = 1'b0;
  logic [1:0] addr_a_in = '0;
  logic [1:0] addr_b_in = '0;
  logic [3:0] data_a_in = '0;
  logic [3:0] data_b_in = '0;
  logic       ack_a_out;
  logic       ack_b_out;
  logic [3:0] set_out;
  logic [3:0] wr_data_out;
  logic       busy_out;
  logic [7:0] wr_count_out;

  int tests = 0;
  int failures = 0;

  // Transaction-level model state
  bit         pend_a, pend_b;
  bit         last_b;
  int         exp_count;
  logic [3:0] exp_regs[4];
  logic [3:0] act_regs[4];

  reg_write_arb #(.DATA_WIDTH(4), .NUM_REGS(4)) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .req_a_in     (req_a_in),
    .req_b_in     (req_b_in),
    .addr_a_in    (addr_a_in),
    .addr_b_in    (addr_b_in),
    .data_a_in    (data_a_in),
    .data_b_in    (data_b_in),
    .ack_a_out    (ack_a_out),
    .ack_b_out    (ack_b_out),
    .set_out      (set_out),
    .wr_data_out  (wr_data_out),
    .busy_out     (busy_out),
    .wr_count_out (wr_count_out)
  );

  always #5 clock_in = ~clock_in;

  // Target register bank driven by the strobe/data broadcast
  always @(posedge clock_in) begin
    for (int i = 0; i < 4; i++) begin
      if (set_out[i] === 1'b1) act_regs[i] <= wr_data_out;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    pend_a    = 1'b0;
    pend_b    = 1'b0;
    last_b    = 1'b1;
    exp_count = 0;
  endtask

  task automatic do_reset();
    tick();
    reset_in = 1'b1;
    req_a_in = 1'b0;
    req_b_in = 1'b0;
    #2;
    checkOutput("rst_set", set_out, 0);
    checkOutput("rst_ack", {ack_a_out, ack_b_out}, 0);
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_data", wr_data_out, 0);
    checkOutput("rst_count", wr_count_out, 0);
    tick();
    reset_in = 1'b0;
    model_reset();
  endtask

  task automatic applyStimulus(input bit b_side, input logic [1:0] addr,
                               input logic [3:0] data);
    if (b_side) begin
      addr_b_in = addr; data_b_in = data; req_b_in = 1'b1; pend_b = 1'b1;
    end else begin
      addr_a_in = addr; data_a_in = data; req_a_in = 1'b1; pend_a = 1'b1;
    end
  endtask

  // One write: predicted winner must be acked on the very next edge.
  task automatic serve_one(input int hold, input bit rereq);
    bit         win_b;
    logic [1:0] a;
    logic [3:0] d;
    logic [3:0] exp_set;
    win_b   = (pend_a && pend_b) ? !last_b : pend_b;
    a       = win_b ? addr_b_in : addr_a_in;
    d       = win_b ? data_b_in : data_a_in;
    exp_set = 4'b0001 << a;
    tick();
    checkOutput("ack_a", ack_a_out, {31'b0, !win_b});
    checkOutput("ack_b", ack_b_out, {31'b0, win_b});
    checkOutput("set", set_out, exp_set);
    checkOutput("wr_data", wr_data_out, d);
    checkOutput("busy_write", busy_out, 1);
    last_b = win_b;
    exp_count++;
    exp_regs[a] = d;
    if (win_b) begin
      pend_b = 1'b0; addr_b_in = 2'($urandom); data_b_in = 4'($urandom);
      if (hold == 0) req_b_in = 1'b0;
    end else begin
      pend_a = 1'b0; addr_a_in = 2'($urandom); data_a_in = 4'($urandom);
      if (hold == 0) req_a_in = 1'b0;
    end
    tick();
    checkOutput("count", wr_count_out, exp_count & 255);
    checkOutput("set_after", set_out, 0);
    checkOutput("ack_after", {ack_a_out, ack_b_out}, 0);
    checkOutput("busy_release", busy_out, 1);
    checkOutput("data_hold", wr_data_out, d);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_busy", busy_out, 1);
      checkOutput("hold_ack", {ack_a_out, ack_b_out}, 0);
      checkOutput("hold_set", set_out, 0);
    end
    if (win_b) req_b_in = 1'b0; else req_a_in = 1'b0;
    for (int i = 0; i < 4 && busy_out; i++) tick();
    checkOutput("idle", busy_out, 0);
    checkOutput("idle_ack", {ack_a_out, ack_b_out}, 0);
    checkOutput("idle_data", wr_data_out, d);
    if (rereq) applyStimulus(win_b, 2'($urandom), 4'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      exp_regs[i] = '0;
      act_regs[i] = '0;
    end
    model_reset();
    do_reset();

    $display("[TB] single write from A");
    applyStimulus(1'b0, 2'd2, 4'hA);
    serve_one(0, 1'b0);
    checkOutput("first_count", wr_count_out, 1);

    $display("[TB] simultaneous A and B after reset");
    do_reset();
    applyStimulus(1'b0, 2'd0, 4'h3);
    applyStimulus(1'b1, 2'd3, 4'hC);
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);
    checkOutput("tie_count", wr_count_out, 2);

    $display("[TB] A holds request after ack");
    applyStimulus(1'b0, 2'd1, 4'h5);
    serve_one(5, 1'b0);

    $display("[TB] continuous alternation");
    applyStimulus(1'b0, 2'($urandom), 4'($urandom));
    applyStimulus(1'b1, 2'($urandom), 4'($urandom));
    for (int i = 0; i < 8; i++) serve_one(0, i < 6);

    $display("[TB] random rounds");
    for (int r = 0; r < 40; r++) begin
      bit ra, rb;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      if (ra) applyStimulus(1'b0, 2'($urandom), 4'($urandom));
      if (rb) applyStimulus(1'b1, 2'($urandom), 4'($urandom));
      while (pend_a || pend_b) serve_one(int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] reset during WRITE");
    applyStimulus(1'b0, 2'($urandom), 4'($urandom));
    tick();
    checkOutput("mid_ack", ack_a_out, 1);
    #2;
    reset_in = 1'b1;
    #1;
    checkOutput("mid_set", set_out, 0);
    checkOutput("mid_acks", {ack_a_out, ack_b_out}, 0);
    checkOutput("mid_count", wr_count_out, 0);
    checkOutput("mid_busy", busy_out, 0);
    req_a_in = 1'b0;
    tick();
    reset_in = 1'b0;
    model_reset();
    tick();
    checkOutput("post_set", set_out, 0);
    checkOutput("post_acks", {ack_a_out, ack_b_out}, 0);
    checkOutput("post_count", wr_count_out, 0);

    $display("[TB] 256 writes wrap the counter");
    for (int n = 0; n < 256; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom));
      serve_one(0, 1'b0);
    end
    checkOutput("wrap_zero", wr_count_out, 0);

    for (int i = 0; i < 4; i++) checkOutput("regfile", act_regs[i], exp_regs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arb.md
REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of every data bus and of each target register.
REQ-002 Parameter NUM_REGS, default 4, number of target registers driven; address width AW = 2 fixed.
REQ-003 clock_in  input  1  clock; all state updates on rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 req_a_in / req_b_in  input  1 each  write request from requester A / B, level, held until ack.
REQ-006 addr_a_in / addr_b_in  input  AW each  target register index of A / B.
REQ-007 data_a_in / data_b_in  input  DATA_WIDTH each  write data of A / B.
REQ-008 ack_a_out / ack_b_out  output  1 each  one-cycle pulse: request performed.
REQ-009 set_out  output  NUM_REGS  one-hot set strobe per target register.
REQ-010 wr_data_out  output  DATA_WIDTH  data broadcast to all target registers.
REQ-011 busy_out  output  1  high whenever the FSM is not IDLE.
REQ-012 wr_count_out  output  8  count of completed writes, wraps 255 -> 0.

Function
REQ-013 FSM states: IDLE, WRITE, RELEASE; one state per clock edge.
REQ-014 IDLE: no request -> stay IDLE; any request -> capture winner id, addr, data into registers; go WRITE.
REQ-015 Arbitration: one requester active -> it wins; both active -> winner is the one NOT granted last (round-robin).
REQ-016 WRITE (exactly one cycle): set_out = one-hot of captured addr, wr_data_out = captured data, winner's ack high; go RELEASE.
REQ-017 Latency: request sampled at edge N, set_out/ack asserted during cycle N+1 (registered outputs, no combinational path from inputs).
REQ-018 Address >= NUM_REGS: set_out all-zero, ack still pulses, wr_count_out still increments.
REQ-019 wr_count_out increments by 1 at end of every WRITE cycle.
REQ-020 last_grant register updates to the winner at the IDLE->WRITE edge.
REQ-021 RELEASE: stay while winner's req still high; when it is low go IDLE (no re-arbitration in the same edge).
REQ-022 Loser's request is neither dropped nor acked; it is served at the next IDLE arbitration.
REQ-023 Outside WRITE: set_out = 0, ack_a_out = ack_b_out = 0; wr_data_out holds last captured value.
REQ-024 Requester input changes while not IDLE are ignored; captured addr/data are stable through WRITE.

Reset
REQ-025 reset_in high: FSM = IDLE, set_out = 0, both acks = 0, busy_out = 0, wr_data_out = 0, wr_count_out = 0, last_grant = B (A wins first tie).
REQ-026 Reset asserted mid-WRITE or RELEASE aborts immediately; no partial strobe after deassertion; the aborted write is not counted.
REQ-027 First arbitration possible at the first rising edge after reset_in deasserts.

Structure
REQ-028 Shared package holds FSM state encoding (IDLE=2'd0, WRITE=2'd1, RELEASE=2'd2), requester ids (REQ_A=1'b0, REQ_B=1'b1) and AW.
REQ-029 Round-robin decision in one sub-module rr_arb2 (inputs: two reqs, last_grant; outputs: valid, winner id), purely combinational.
REQ-030 Unused state encoding 2'd3 returns to IDLE on the next edge.

Verification
REQ-031 Reset, then A req, addr=2, data=4'hA -> cycle N+1: set_out=4'b0100, wr_data_out=4'hA, ack_a_out=1, wr_count_out=1 after.
REQ-032 A and B req in same cycle after reset (A=addr0/4'h3, B=addr3/4'hC) -> A served first (set_out=4'b0001), after A drops, B served (set_out=4'b1000, 4'hC); count=2.
REQ-033 A holds req high 5 cycles after ack -> exactly one set_out pulse, busy_out high throughout, no second ack.
REQ-034 A and B continuously re-requesting with immediate drop after ack -> grants alternate A,B,A,B for 8 writes.
REQ-035 reset_in pulsed during WRITE cycle -> set_out and acks 0 the same cycle, wr_count_out=0, FSM IDLE.
REQ-036 256 single writes -> wr_count_out wraps to 0 after the 256th ack.
